// File: rtl/unigate_pkg.sv
// unigate_pkg: register map, bit positions and shifter states shared by the config loader
package unigate_pkg;
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam int CTRL_CFG_EN = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLEAR  = 2;
  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
endpackage

// File: rtl/unigate_cfg_shifter.sv
// unigate_cfg_shifter: serialises 32-bit words LSB first into the chain and latches it when full
module unigate_cfg_shifter
  import unigate_pkg::*;
#(
  parameter int CHAIN_LEN = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] word,
  output logic        busy,
  output logic        done_pulse,
  output logic [15:0] count,
  output logic        cfg_data,
  output logic        cfg_shift,
  output logic        cfg_latch
);
  localparam logic [15:0] LEN = 16'(CHAIN_LEN);
  state_t state, state_n;
  logic [31:0] shreg, shreg_n;
  logic [4:0] bitcnt, bitcnt_n;
  logic [15:0] count_n, count_inc;
  logic data_n, shift_n, latch_n;
  assign busy = state != IDLE;
  assign done_pulse = (state == LATCH) & ~clear;
  assign count_inc = count == LEN ? count : count + 16'd1;
  // Next bit is staged into the output flops so each strobe lines up with the count that includes it
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    bitcnt_n = bitcnt;
    count_n = count;
    data_n = 1'b0;
    shift_n = 1'b0;
    latch_n = 1'b0;
    if (clear) begin
      state_n = IDLE;
      count_n = '0;
    end else begin
      case (state)
        IDLE: if (load) begin
          state_n = SHIFT;
          shreg_n = word >> 1;
          bitcnt_n = '0;
          data_n = word[0];
          shift_n = 1'b1;
          count_n = count_inc;
        end
        SHIFT: if (count == LEN) begin
          state_n = LATCH;
          latch_n = 1'b1;
        end else if (bitcnt == 5'd31) begin
          state_n = IDLE;
        end else begin
          shreg_n = shreg >> 1;
          bitcnt_n = bitcnt + 5'd1;
          data_n = shreg[0];
          shift_n = 1'b1;
          count_n = count_inc;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  // State, datapath and registered strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      bitcnt <= '0;
      count <= '0;
      cfg_data <= 1'b0;
      cfg_shift <= 1'b0;
      cfg_latch <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      bitcnt <= bitcnt_n;
      count <= count_n;
      cfg_data <= data_n;
      cfg_shift <= shift_n;
      cfg_latch <= latch_n;
    end
  end
endmodule

// File: rtl/unigate_cfg_loader.sv
// unigate_cfg_loader: Wishbone slave that streams configuration words into the unigate chain
module unigate_cfg_loader
  import unigate_pkg::*;
#(
  parameter logic [31:0] BASE_ADR  = 32'h3000_0000,
  parameter int          CHAIN_LEN = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        cfg_data_o,
  output logic        cfg_shift_o,
  output logic        cfg_latch_o,
  output logic        cfg_en_o,
  output logic        irq_o
);
  logic req, stall, wr, load, ctrl_wr, clear, w1c, busy, done, done_pulse, irq_en, unused;
  logic [1:0] off;
  logic [15:0] count;
  logic [31:0] rdata;
  assign off = wbs_adr_i[3:2];
  assign req = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign stall = wbs_we_i & (off == REG_DATA) & busy;
  assign wr = wbs_ack_o & req & wbs_we_i;
  assign load = wr & (off == REG_DATA) & ~done;
  assign ctrl_wr = wr & (off == REG_CTRL) & wbs_sel_i[0];
  assign clear = ctrl_wr & wbs_dat_i[CTRL_CLEAR];
  assign w1c = wr & (off == REG_STATUS) & wbs_dat_i[STAT_DONE];
  assign irq_o = done & irq_en;
  assign wbs_dat_o = wbs_ack_o ? rdata : '0;
  assign unused = &{1'b0, wbs_adr_i[1:0], wbs_sel_i[3:1]};
  // Read mux; DATA and the reserved slot read as zero
  always_comb begin
    rdata = '0;
    if (off == REG_CTRL) begin
      rdata[CTRL_CFG_EN] = cfg_en_o;
      rdata[CTRL_IRQ_EN] = irq_en;
    end else if (off == REG_STATUS) begin
      rdata[31:16] = count;
      rdata[STAT_BUSY] = busy;
      rdata[STAT_DONE] = done;
    end
  end
  // Single-cycle ack, never back to back; DATA writes wait while the shifter is busy
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) wbs_ack_o <= 1'b0;
    else wbs_ack_o <= req & ~wbs_ack_o & ~stall;
  end
  // CTRL register; the clear bit is a pulse and is not stored
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cfg_en_o <= 1'b0;
      irq_en <= 1'b0;
    end else if (ctrl_wr) begin
      cfg_en_o <= wbs_dat_i[CTRL_CFG_EN];
      irq_en <= wbs_dat_i[CTRL_IRQ_EN];
    end
  end
  // Done flag: a latch completing beats a simultaneous write-one-to-clear
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) done <= 1'b0;
    else done <= done_pulse ? 1'b1 : (clear | w1c) ? 1'b0 : done;
  end
  unigate_cfg_shifter #(.CHAIN_LEN(CHAIN_LEN)) u_shifter (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .load(load),
    .clear(clear),
    .word(wbs_dat_i),
    .busy(busy),
    .done_pulse(done_pulse),
    .count(count),
    .cfg_data(cfg_data_o),
    .cfg_shift(cfg_shift_o),
    .cfg_latch(cfg_latch_o)
  );
endmodule

// File: tb/tb_unigate_cfg_loader.sv
// tb_unigate_cfg_loader: directed checks of the config loader with a 40-bit chain
module tb_unigate_cfg_loader;
  localparam logic [31:0] BASE = 32'h3000_0000;
  logic clk = 0, rst = 1, cyc = 0, stb = 0, we = 0;
  logic [3:0] sel = 0;
  logic [31:0] adr = 0, dat = 0;
  logic ack, cfg_data, cfg_shift, cfg_latch, cfg_en, irq;
  logic [31:0] dat_o;
  int errors = 0, checks = 0, nshift = 0, nlatch = 0;
  logic [63:0] bits = 0;
  unigate_cfg_loader #(.BASE_ADR(BASE), .CHAIN_LEN(40)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .cfg_data_o(cfg_data), .cfg_shift_o(cfg_shift), .cfg_latch_o(cfg_latch),
    .cfg_en_o(cfg_en), .irq_o(irq)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (cfg_shift) begin
      if (nshift < 64) bits[nshift] = cfg_data;
      nshift++;
    end
    if (cfg_latch) nlatch++;
  end
  task automatic cyc_wait(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask
  task automatic wb(input logic [31:0] a, input logic [31:0] d, input logic w, input int limit,
                    output logic [31:0] rd, output int n, output logic acked);
    cyc = 1; stb = 1; we = w; adr = a; dat = d; sel = 4'hF; n = 0; acked = 0; rd = 0;
    while (!acked && n < limit) begin
      @(posedge clk); #1; n++;
      if (ack) begin acked = 1; rd = dat_o; end
    end
    if (acked) begin @(posedge clk); #1; end
    cyc = 0; stb = 0; we = 0;
  endtask
  task automatic test_reset;
    logic [31:0] rd; int n; logic a;
    cyc_wait(2); rst = 0; cyc_wait(1);
    checks++; if ({ack, dat_o, cfg_data, cfg_shift, cfg_latch, cfg_en, irq} !== 38'h0) begin errors++; $display("FAIL reset_outputs: got %h want 0", {ack, dat_o, cfg_data, cfg_shift, cfg_latch, cfg_en, irq}); end
    nlatch = 0;
    wb(BASE, 32'hFFFF_FFFF, 1, 8, rd, n, a);
    cyc_wait(3);
    checks++; if (cfg_shift !== 1'b1) begin errors++; $display("FAIL reset_preshift: got %b want 1", cfg_shift); end
    #2 rst = 1; #1;
    checks++; if ({ack, dat_o, cfg_data, cfg_shift, cfg_latch, cfg_en, irq} !== 38'h0) begin errors++; $display("FAIL reset_midshift: got %h want 0", {ack, dat_o, cfg_data, cfg_shift, cfg_latch, cfg_en, irq}); end
    @(posedge clk); #1 rst = 0;
    wb(BASE + 8, 0, 0, 8, rd, n, a);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 0", rd); end
    cyc_wait(4);
    checks++; if (nlatch !== 0) begin errors++; $display("FAIL reset_nolatch: got %0d want 0", nlatch); end
  endtask
  task automatic test_shift;
    logic [31:0] rd; int n; logic a;
    nshift = 0; bits = 0;
    wb(BASE, 32'hA5A5_0F0F, 1, 8, rd, n, a);
    checks++; if (n !== 1) begin errors++; $display("FAIL shift_ack_latency: got %0d want 1", n); end
    checks++; if ({cfg_shift, cfg_data} !== 2'b11) begin errors++; $display("FAIL shift_first_strobe: got %b want 11", {cfg_shift, cfg_data}); end
    cyc_wait(30);
    wb(BASE + 8, 0, 0, 8, rd, n, a);
    checks++; if (rd !== 32'h0020_0001) begin errors++; $display("FAIL shift_status_busy: got %h want 00200001", rd); end
    checks++; if (nshift !== 32) begin errors++; $display("FAIL shift_count: got %0d want 32", nshift); end
    checks++; if (bits[31:0] !== 32'hA5A5_0F0F) begin errors++; $display("FAIL shift_bits: got %h want a5a50f0f", bits[31:0]); end
    checks++; if (cfg_shift !== 1'b0) begin errors++; $display("FAIL shift_stopped: got %b want 0", cfg_shift); end
    wb(BASE + 8, 0, 0, 8, rd, n, a);
    checks++; if (rd !== 32'h0020_0000) begin errors++; $display("FAIL shift_status_end: got %h want 00200000", rd); end
  endtask
  task automatic test_back_to_back;
    logic [31:0] rd; int n; logic a;
    wb(BASE + 4, 32'h4, 1, 8, rd, n, a);
    nshift = 0; nlatch = 0; bits = 0;
    wb(BASE, 32'h1357_9BDF, 1, 8, rd, n, a);
    wb(BASE, 32'h0000_00C3, 1, 64, rd, n, a);
    checks++; if (n !== 33) begin errors++; $display("FAIL b2b_ack_wait: got %0d want 33", n); end
    cyc_wait(12);
    checks++; if (nshift !== 40) begin errors++; $display("FAIL b2b_shifts: got %0d want 40", nshift); end
    checks++; if (bits[39:0] !== 40'hC3_1357_9BDF) begin errors++; $display("FAIL b2b_bits: got %h want c313579bdf", bits[39:0]); end
    checks++; if (nlatch !== 1) begin errors++; $display("FAIL b2b_latch: got %0d want 1", nlatch); end
    wb(BASE + 8, 0, 0, 8, rd, n, a);
    checks++; if (rd !== 32'h0028_0002) begin errors++; $display("FAIL b2b_status: got %h want 00280002", rd); end
  endtask
  task automatic test_irq;
    logic [31:0] rd; int n; logic a;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked: got %b want 0", irq); end
    wb(BASE + 4, 32'h3, 1, 8, rd, n, a);
    checks++; if ({irq, cfg_en} !== 2'b11) begin errors++; $display("FAIL irq_enabled: got %b want 11", {irq, cfg_en}); end
    wb(BASE + 4, 0, 0, 8, rd, n, a);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL irq_ctrl_read: got %h want 3", rd); end
    wb(BASE + 8, 32'h2, 1, 8, rd, n, a);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_w1c: got %b want 0", irq); end
    wb(BASE + 8, 0, 0, 8, rd, n, a);
    checks++; if (rd !== 32'h0028_0000) begin errors++; $display("FAIL irq_status_w1c: got %h want 00280000", rd); end
    wb(BASE + 4, 32'h7, 1, 8, rd, n, a);
    nlatch = 0;
    wb(BASE, 32'hFFFF_FFFF, 1, 8, rd, n, a);
    wb(BASE, 32'hFFFF_FFFF, 1, 64, rd, n, a);
    cyc_wait(7);
    wb(BASE + 8, 32'h2, 1, 8, rd, n, a);
    checks++; if ({nlatch == 1, irq} !== 2'b11) begin errors++; $display("FAIL irq_set_wins: got latch=%0d irq=%b want latch=1 irq=1", nlatch, irq); end
    wb(BASE + 8, 0, 0, 8, rd, n, a);
    checks++; if (rd !== 32'h0028_0002) begin errors++; $display("FAIL irq_set_wins_status: got %h want 00280002", rd); end
  endtask
  task automatic test_clear;
    logic [31:0] rd; int n; logic a; int snap;
    wb(BASE + 4, 32'h4, 1, 8, rd, n, a);
    wb(BASE + 8, 0, 0, 8, rd, n, a);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL clear_idle_status: got %h want 0", rd); end
    nshift = 0;
    wb(BASE, 32'h1234_5678, 1, 8, rd, n, a);
    cyc_wait(5);
    wb(BASE + 4, 32'h4, 1, 8, rd, n, a);
    checks++; if ({cfg_shift, cfg_data, cfg_latch} !== 3'b000) begin errors++; $display("FAIL clear_strobes: got %b want 000", {cfg_shift, cfg_data, cfg_latch}); end
    snap = nshift;
    cyc_wait(5);
    checks++; if (nshift !== 7 || snap !== 7) begin errors++; $display("FAIL clear_shift_count: got %0d/%0d want 7", snap, nshift); end
    wb(BASE + 8, 0, 0, 8, rd, n, a);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL clear_status: got %h want 0", rd); end
    wb(BASE, 32'h0000_0001, 1, 8, rd, n, a);
    checks++; if ({n == 1, cfg_shift, cfg_data} !== 3'b111) begin errors++; $display("FAIL clear_reload: got n=%0d shift=%b data=%b want 1,1,1", n, cfg_shift, cfg_data); end
    cyc_wait(32);
    wb(BASE + 8, 0, 0, 8, rd, n, a);
    checks++; if (rd !== 32'h0020_0000) begin errors++; $display("FAIL clear_reload_status: got %h want 00200000", rd); end
  endtask
  task automatic test_decode;
    logic [31:0] rd; int n; logic a; int acks, dbl; logic prev;
    wb(BASE + 16, 0, 0, 16, rd, n, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL decode_miss: got ack=%b want 0", a); end
    wb(BASE + 12, 0, 0, 8, rd, n, a);
    checks++; if ({a, n == 1} !== 2'b11 || rd !== 32'h0) begin errors++; $display("FAIL decode_reserved: got ack=%b n=%0d rd=%h want 1,1,0", a, n, rd); end
    wb(BASE, 0, 0, 8, rd, n, a);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL decode_data_read: got %h want 0", rd); end
    cyc = 1; stb = 1; we = 0; adr = BASE + 12; acks = 0; dbl = 0; prev = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
      if (ack && prev) dbl++;
      prev = ack;
    end
    cyc = 0; stb = 0;
    checks++; if (acks !== 4 || dbl !== 0) begin errors++; $display("FAIL decode_ack_alternate: got acks=%0d doubles=%0d want 4,0", acks, dbl); end
  endtask
  initial begin
    test_reset();
    test_shift();
    test_back_to_back();
    test_irq();
    test_clear();
    test_decode();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
